// File: rtl/suansha_pkg.sv
// rtl/suansha_pkg.sv - shared board type, cell codes and scheduler states for the kill-search chain
package suansha_pkg;

  localparam int N_CELLS          = 225;
  localparam int MAX_ENGINE_DEPTH = 8;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] OWN   = 2'd1;
  localparam logic [1:0] OPP   = 2'd2;

  typedef logic [N_CELLS-1:0][1:0] board;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_ABORT,
    S_NEXT,
    S_DONE
  } sched_state_e;

  // Reserved code 3 and EMPTY pass through untouched.
  function automatic logic [1:0] swap_cell(input logic [1:0] c);
    logic [1:0] r;
    r = c;
    if (c == OWN) r = OPP;
    else if (c == OPP) r = OWN;
    return r;
  endfunction

endpackage

// File: rtl/suansha_board_swap.sv
// rtl/suansha_board_swap.sv - combinational own/opponent colour swap over a full board
module board_swap
  import suansha_pkg::*;
(
  input  board i_board,
  output board o_board
);

  always_comb begin
    o_board = i_board;
    for (int i = 0; i < N_CELLS; i++) begin
      o_board[i] = swap_cell(i_board[i]);
    end
  end

endmodule

// File: rtl/suansha_scheduler.sv
// rtl/suansha_scheduler.sv - runs own-side then opponent-side iterative-deepening kill searches on one engine
module suansha_scheduler
  import suansha_pkg::*;
#(
  parameter int DEPTH_MIN  = 2,
  parameter int DEPTH_STEP = 2,
  parameter int DEPTH_MAX  = 8,
  parameter int BUDGET     = 1_000_000,
  parameter int CNT_W      = 20,
  parameter int ABORT_CYC  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  board       i_board,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_own_sha,
  output logic       o_opp_sha,
  output logic [4:0] o_own_depth,
  output logic [4:0] o_opp_depth,
  output logic       o_timeout,
  output logic       o_eng_start,
  output logic [4:0] o_eng_depth,
  output board       o_eng_board,
  output logic       o_eng_abort,
  input  logic       i_eng_sha,
  input  logic       i_eng_finish
);

  localparam int AW = (ABORT_CYC > 1) ? $clog2(ABORT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BUDGET - 1);
  localparam logic [AW-1:0]    ABORT_LAST = AW'(ABORT_CYC - 1);
  localparam logic [5:0]       D_MIN      = 6'(DEPTH_MIN);
  localparam logic [5:0]       D_STEP     = 6'(DEPTH_STEP);
  localparam logic [5:0]       D_MAX      = 6'(DEPTH_MAX);

  sched_state_e     state_q, state_d;
  board             board_q, board_d;
  board             board_sw;
  logic             qry_q, qry_d;
  logic [5:0]       dep_q, dep_d;
  logic [5:0]       dep_step;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acnt_q, acnt_d;
  logic             pend_q, pend_d;
  logic             own_sha_q, own_sha_d;
  logic             opp_sha_q, opp_sha_d;
  logic [4:0]       own_dep_q, own_dep_d;
  logic [4:0]       opp_dep_q, opp_dep_d;
  logic             tout_q, tout_d;
  logic             rec_en, rec_sha;
  logic [4:0]       rec_dep;

  board_swap u_swap (
    .i_board (board_q),
    .o_board (board_sw)
  );

  assign dep_step = dep_q + D_STEP;

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    qry_d     = qry_q;
    dep_d     = dep_q;
    cnt_d     = cnt_q;
    acnt_d    = acnt_q;
    pend_d    = pend_q;
    own_sha_d = own_sha_q;
    opp_sha_d = opp_sha_q;
    own_dep_d = own_dep_q;
    opp_dep_d = opp_dep_q;
    tout_d    = tout_q;
    rec_en    = 1'b0;
    rec_sha   = 1'b0;
    rec_dep   = 5'd0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          board_d   = i_board;
          qry_d     = 1'b0;
          dep_d     = D_MIN;
          cnt_d     = '0;
          pend_d    = 1'b0;
          own_sha_d = 1'b0;
          opp_sha_d = 1'b0;
          own_dep_d = 5'd0;
          opp_dep_d = 5'd0;
          tout_d    = 1'b0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A finish in the expiry cycle still counts as a clean result.
        if (i_eng_finish) begin
          state_d = S_NEXT;
          if (i_eng_sha) begin
            rec_en  = 1'b1;
            rec_sha = 1'b1;
            rec_dep = dep_q[4:0];
          end else if (dep_step <= D_MAX) begin
            dep_d  = dep_step;
            pend_d = 1'b1;
          end else begin
            rec_en = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          acnt_d  = '0;
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (acnt_q == ABORT_LAST) begin
          rec_en  = 1'b1;
          tout_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          acnt_d = acnt_q + AW'(1);
        end
      end
      S_NEXT: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_LAUNCH;
        end else if (!qry_q) begin
          qry_d   = 1'b1;
          cnt_d   = '0;
          dep_d   = D_MIN;
          state_d = S_LAUNCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rec_en) begin
      if (qry_q) begin
        opp_sha_d = rec_sha;
        opp_dep_d = rec_dep;
      end else begin
        own_sha_d = rec_sha;
        own_dep_d = rec_dep;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      qry_q     <= 1'b0;
      dep_q     <= 6'd0;
      cnt_q     <= '0;
      acnt_q    <= '0;
      pend_q    <= 1'b0;
      own_sha_q <= 1'b0;
      opp_sha_q <= 1'b0;
      own_dep_q <= 5'd0;
      opp_dep_q <= 5'd0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      qry_q     <= qry_d;
      dep_q     <= dep_d;
      cnt_q     <= cnt_d;
      acnt_q    <= acnt_d;
      pend_q    <= pend_d;
      own_sha_q <= own_sha_d;
      opp_sha_q <= opp_sha_d;
      own_dep_q <= own_dep_d;
      opp_dep_q <= opp_dep_d;
      tout_q    <= tout_d;
    end
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_eng_start = (state_q == S_LAUNCH);
  assign o_eng_abort = (state_q == S_ABORT);
  assign o_eng_depth = dep_q[4:0];
  assign o_eng_board = qry_q ? board_sw : board_q;
  assign o_own_sha   = own_sha_q;
  assign o_opp_sha   = opp_sha_q;
  assign o_own_depth = own_dep_q;
  assign o_opp_depth = opp_dep_q;
  assign o_timeout   = tout_q;

endmodule

// File: tb/tb_suansha_scheduler.sv
// tb/tb_suansha_scheduler.sv - directed checks of the kill-search scheduler against a small engine model
module tb_suansha_scheduler;
  import suansha_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, eng_sha, eng_finish;
  board       brd;
  logic       busy, done, own_sha, opp_sha, tout, eng_start, eng_abort;
  logic [4:0] own_dep, opp_dep, eng_dep;
  board       eng_board;

  always #5 clk = ~clk;

  suansha_scheduler #(
    .DEPTH_MIN(2), .DEPTH_STEP(2), .DEPTH_MAX(8),
    .BUDGET(16), .CNT_W(5), .ABORT_CYC(2)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_board(brd),
    .o_busy(busy), .o_done(done),
    .o_own_sha(own_sha), .o_opp_sha(opp_sha),
    .o_own_depth(own_dep), .o_opp_depth(opp_dep),
    .o_timeout(tout), .o_eng_start(eng_start), .o_eng_depth(eng_dep),
    .o_eng_board(eng_board), .o_eng_abort(eng_abort),
    .i_eng_sha(eng_sha), .i_eng_finish(eng_finish)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Engine model: latency in WAIT cycles (0 = never finishes), kill depth (0 = no kill).
  int         lat_own = 1, lat_opp = 1, kd_own = 0, kd_opp = 0;
  int         wait_n = 0, lat_sel, kd_sel;
  logic       cur_sha = 1'b0;
  int         launch_dep[$];
  logic [5:0] launch_cells[$];
  int         abort_cnt = 0, done_cnt = 0, cyc = 0, busy_rise = 0, done_cyc = 0;
  logic       busy_prev = 1'b0;
  int         exp_dep[6] = '{2, 4, 2, 4, 6, 8};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    eng_finish = 1'b0;
    eng_sha    = 1'b0;
    if (!busy || eng_abort) begin
      wait_n = 0;
    end else if (eng_start) begin
      launch_dep.push_back(int'(eng_dep));
      launch_cells.push_back({eng_board[0], eng_board[1], eng_board[2]});
      lat_sel = (eng_board[0] == OPP) ? lat_opp : lat_own;
      kd_sel  = (eng_board[0] == OPP) ? kd_opp : kd_own;
      wait_n  = lat_sel;
      cur_sha = (kd_sel != 0) && (int'(eng_dep) >= kd_sel);
    end else if (wait_n > 0) begin
      wait_n--;
      if (wait_n == 0) begin
        eng_finish = 1'b1;
        eng_sha    = cur_sha;
      end
    end
    if (eng_abort) abort_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !busy_prev) busy_rise = cyc;
    busy_prev = busy;
  end

  task automatic clear_logs();
    launch_dep.delete();
    launch_cells.delete();
    abort_cnt = 0;
    done_cnt  = 0;
  endtask

  // Called at a negedge while idle; returns at the negedge of the o_done cycle.
  task automatic run_search(input int max_cyc);
    logic seen;
    seen = 1'b0;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    brd   = '0;
    brd[0] = OWN;
    brd[1] = OPP;
    brd[2] = 2'd3;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_eng_start", 32'(eng_start), 0);
    check("rst_eng_abort", 32'(eng_abort), 0);
    check("rst_eng_depth", 32'(eng_dep), 0);
    check("rst_eng_board_empty", 32'(eng_board == '0), 1);
    check("rst_own_sha", 32'(own_sha), 0);
    check("rst_opp_depth", 32'(opp_dep), 0);
    check("rst_timeout", 32'(tout), 0);

    // Own kill at depth 4, opponent never: full deepening on q=1.
    lat_own = 2; lat_opp = 2; kd_own = 4; kd_opp = 0;
    run_search(200);
    check("k4_own_sha", 32'(own_sha), 1);
    check("k4_own_depth", 32'(own_dep), 4);
    check("k4_opp_sha", 32'(opp_sha), 0);
    check("k4_opp_depth", 32'(opp_dep), 0);
    check("k4_timeout", 32'(tout), 0);
    check("k4_launches", launch_dep.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("k4_launch_depth%0d", i), (launch_dep.size() > i) ? launch_dep[i] : -1, exp_dep[i]);
    check("swap_q0_cells", (launch_cells.size() > 0) ? 32'(launch_cells[0]) : 32'hFFFF, 32'h1B);
    check("swap_q1_cells", (launch_cells.size() > 2) ? 32'(launch_cells[2]) : 32'hFFFF, 32'h27);
    @(negedge clk);

    // Own query never finishes: abort, then opponent query still runs.
    lat_own = 0; lat_opp = 1; kd_own = 2; kd_opp = 2;
    run_search(200);
    check("to_abort_cycles", abort_cnt, 2);
    check("to_timeout", 32'(tout), 1);
    check("to_own_sha", 32'(own_sha), 0);
    check("to_own_depth", 32'(own_dep), 0);
    check("to_opp_sha", 32'(opp_sha), 1);
    check("to_opp_depth", 32'(opp_dep), 2);
    check("to_launches", launch_dep.size(), 2);
    check("to_q1_cells", (launch_cells.size() > 1) ? 32'(launch_cells[1]) : 32'hFFFF, 32'h27);
    @(negedge clk);

    // Finish with a kill in the budget-expiry cycle.
    lat_own = 16; lat_opp = 1; kd_own = 2; kd_opp = 0;
    run_search(200);
    check("tie_own_sha", 32'(own_sha), 1);
    check("tie_own_depth", 32'(own_dep), 2);
    check("tie_timeout", 32'(tout), 0);
    check("tie_abort_cycles", abort_cnt, 0);
    @(negedge clk);

    // Best case with a second start while busy.
    lat_own = 1; lat_opp = 1; kd_own = 2; kd_opp = 2;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("bc_done_count", done_cnt, 1);
    check("bc_latency", done_cyc - busy_rise, 6);
    check("bc_own_depth", 32'(own_dep), 2);
    check("bc_opp_sha", 32'(opp_sha), 1);
    check("bc_busy_after", 32'(busy), 0);

    // Reset in the middle of WAIT, then a normal run.
    lat_own = 0; kd_own = 2;
    clear_logs();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_in_wait_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_eng_start", 32'(eng_start), 0);
    check("mid_rst_eng_abort", 32'(eng_abort), 0);
    check("mid_rst_eng_depth", 32'(eng_dep), 0);
    check("mid_rst_board_empty", 32'(eng_board == '0), 1);
    check("mid_rst_done", 32'(done), 0);
    lat_own = 1; lat_opp = 1; kd_own = 2; kd_opp = 4;
    run_search(200);
    check("post_own_sha", 32'(own_sha), 1);
    check("post_own_depth", 32'(own_dep), 2);
    check("post_opp_depth", 32'(opp_dep), 4);
    check("post_timeout", 32'(tout), 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
